// File: rtl/sr_drive_seq.sv
// -----------------------------------------------------------------------------
// sr_drive_seq
//
// Command sequencer in front of an SR latch. It takes hold/reset/set commands
// over a valid/ready handshake. Each command becomes a timed sequence on the
// latch inputs: a setup cycle with sr driven and E low, then HOLD_CYCLES with
// E high, then GAP_CYCLES with E low. The forbidden S=R=1 code never reaches
// the latch. Instead it raises a sticky error and bumps a saturating reject
// count. A shadow copy of the expected latch Q is kept so it can be compared
// against the real latch output.
//
// Parameters
//   HOLD_CYCLES  cycles E is held high per command (>= 1)
//   GAP_CYCLES   cycles E is held low after the pulse (>= 0)
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   cmd_valid  in   command present
//   cmd[1:0]   in   00 hold, 01 reset, 10 set, 11 forbidden
//   cmd_ready  out  sequencer accepts a command this cycle (IDLE, not in reset)
//   err_clr    in   clears the sticky err flag
//   sr[1:0]    out  to latch: sr[1] = S, sr[0] = R
//   E          out  to latch enable
//   busy       out  a command is in progress
//   err        out  sticky: a forbidden command was accepted
//   rej_cnt    out  forbidden commands rejected, saturating at 255
//   q_shadow   out  expected latch Q after the last executed command
// -----------------------------------------------------------------------------
module sr_drive_seq #(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic       err_clr,
  output logic [1:0] sr,
  output logic       E,
  output logic       busy,
  output logic       err,
  output logic [7:0] rej_cnt,
  output logic       q_shadow
);

  localparam logic [1:0] CMD_RESET  = 2'b01;
  localparam logic [1:0] CMD_SET    = 2'b10;
  localparam logic [1:0] CMD_FORBID = 2'b11;

  // One down-counter times both PULSE and GAP, so it is sized for the longer.
  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // The counter is loaded with length-1 and the phase ends when it reaches 0.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             forbid_acc;

  // cmd_ready is the one output that is decoded rather than registered.
  // Gating it with rst means no command is taken on a reset edge.
  assign cmd_ready  = (state == IDLE) && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign forbid_acc = accept && (cmd == CMD_FORBID);

  // The sr register doubles as the latched command. It holds the command from
  // SETUP through GAP and returns to 00 in IDLE. Only legal codes are ever
  // loaded, so sr can never be 11.
  // NOTE: every register here is written with non-blocking assignments, so all
  // of them update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= 2'b00;
      E        <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      rej_cnt  <= 8'd0;
      q_shadow <= 1'b0;
    end else begin
      // If a forbidden accept and err_clr happen on the same edge, set wins.
      if (forbid_acc) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      if (forbid_acc && (rej_cnt != 8'hFF)) begin
        rej_cnt <= rej_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (accept && (cmd != CMD_FORBID)) begin
            state <= SETUP;
            sr    <= cmd;
            busy  <= 1'b1;
          end
        end

        SETUP: begin
          state <= PULSE;
          E     <= 1'b1;
          cnt   <= HOLD_LOAD;
        end

        PULSE: begin
          if (cnt == '0) begin
            E <= 1'b0;
            // The latch captures on this edge, so the shadow follows it here.
            // A hold command leaves the shadow unchanged.
            if (sr == CMD_SET) begin
              q_shadow <= 1'b1;
            end else if (sr == CMD_RESET) begin
              q_shadow <= 1'b0;
            end
            if (GAP_CYCLES > 0) begin
              state <= GAP;
              cnt   <= GAP_LOAD;
            end else begin
              state <= IDLE;
              sr    <= 2'b00;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
            sr    <= 2'b00;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_drive_seq.sv
// -----------------------------------------------------------------------------
// tb_sr_drive_seq
//
// Two sequencers are instantiated: the default timing (2/1) and the tightest
// legal corner (1/0). A driver task applies one cycle of stimulus per call and
// advances a transaction-level reference model. The model tracks when the
// sequencer is next ready, the sticky error, the reject count and the shadow
// Q. For every accepted command it pushes the expected pulse shape into a
// per-instance queue. A negedge monitor rebuilds each executed command from
// busy/E/sr and pops the queue to compare.
// -----------------------------------------------------------------------------
module tb_sr_drive_seq;

  localparam int H0 = 2;
  localparam int G0 = 1;
  localparam int H1 = 1;
  localparam int G1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       [2];
  logic       cmd_valid [2];
  logic [1:0] cmd       [2];
  logic       err_clr   [2];
  logic       cmd_ready [2];
  logic [1:0] sr        [2];
  logic       e_out     [2];
  logic       busy      [2];
  logic       err       [2];
  logic [7:0] rej_cnt   [2];
  logic       q_shadow  [2];

  sr_drive_seq #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0)) dut0 (
    .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd(cmd[0]),
    .cmd_ready(cmd_ready[0]), .err_clr(err_clr[0]), .sr(sr[0]), .E(e_out[0]),
    .busy(busy[0]), .err(err[0]), .rej_cnt(rej_cnt[0]), .q_shadow(q_shadow[0])
  );

  sr_drive_seq #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1)) dut1 (
    .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd(cmd[1]),
    .cmd_ready(cmd_ready[1]), .err_clr(err_clr[1]), .sr(sr[1]), .E(e_out[1]),
    .busy(busy[1]), .err(err[1]), .rej_cnt(rej_cnt[1]), .q_shadow(q_shadow[1])
  );

  typedef struct {
    logic [1:0] sr;
    int         setup;
    int         pulse;
    int         gap;
    logic       q;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Reference model state, one entry per instance.
  int   ready_at [2];
  logic m_err    [2];
  int   m_rej    [2];
  logic m_q      [2];

  // Monitor reconstruction state.
  logic       prev_rst  [2];
  logic       in_prog   [2];
  logic [1:0] rec_sr    [2];
  int         n_setup   [2];
  int         n_pulse   [2];
  int         n_gap     [2];
  logic       shape_bad [2];
  logic       sr_chg    [2];

  function automatic int hc(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  function automatic int gc(input int i);
    return (i == 0) ? G0 : G1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus for instance i. First it checks the registered
  // status against the model, then it drives the inputs and checks cmd_ready.
  // Last, it advances the model as of the coming edge.
  task automatic step(input int i, input logic v, input logic [1:0] c,
                      input logic clr, input logic r, output logic acc);
    logic rdy;
    exp_t e;
    @(posedge clk);
    #1;
    check($sformatf("err[%0d]", i), err[i], m_err[i]);
    check($sformatf("rej_cnt[%0d]", i), rej_cnt[i], m_rej[i]);
    rst[i]       = r;
    cmd_valid[i] = v;
    cmd[i]       = c;
    err_clr[i]   = clr;
    #1;
    rdy = !r && (cyc >= ready_at[i]);
    check($sformatf("cmd_ready[%0d]", i), cmd_ready[i], rdy);
    acc = v && rdy;
    if (r) begin
      ready_at[i] = cyc + 1;
      m_err[i]    = 1'b0;
      m_rej[i]    = 0;
      m_q[i]      = 1'b0;
      if (i == 0) sb0.delete();
      else        sb1.delete();
    end else if (acc && (c == 2'b11)) begin
      m_err[i] = 1'b1;
      if (m_rej[i] < 255) m_rej[i]++;
    end else begin
      if (clr) m_err[i] = 1'b0;
      if (acc) begin
        if (c == 2'b10)      m_q[i] = 1'b1;
        else if (c == 2'b01) m_q[i] = 1'b0;
        e = '{sr: c, setup: 1, pulse: hc(i), gap: gc(i), q: m_q[i]};
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        // Command cycle, setup, pulse and gap all pass before the next IDLE.
        ready_at[i] = cyc + 2 + hc(i) + gc(i);
      end
    end
  endtask

  task automatic idle(input int i, input int n);
    logic acc;
    repeat (n) step(i, 1'b0, 2'b00, 1'b0, 1'b0, acc);
  endtask

  // Monitor: rebuild each executed command from busy/E/sr and score it.
  always @(negedge clk) begin : mon
    exp_t e;
    logic have;
    for (int i = 0; i < 2; i++) begin
      if (prev_rst[i]) begin
        check($sformatf("rst_sr[%0d]", i), sr[i], 0);
        check($sformatf("rst_e[%0d]", i), e_out[i], 0);
        check($sformatf("rst_busy[%0d]", i), busy[i], 0);
        check($sformatf("rst_q[%0d]", i), q_shadow[i], 0);
      end
      check($sformatf("sr_is_11[%0d]", i), (sr[i] == 2'b11), 0);

      if (rst[i]) begin
        in_prog[i] = 1'b0;
      end else if (busy[i]) begin
        if (!in_prog[i]) begin
          in_prog[i]   = 1'b1;
          rec_sr[i]    = sr[i];
          n_setup[i]   = 0;
          n_pulse[i]   = 0;
          n_gap[i]     = 0;
          shape_bad[i] = 1'b0;
          sr_chg[i]    = 1'b0;
        end
        if (sr[i] !== rec_sr[i]) sr_chg[i] = 1'b1;
        if (e_out[i]) begin
          if (n_gap[i] > 0) shape_bad[i] = 1'b1;
          n_pulse[i]++;
        end else if (n_pulse[i] == 0) begin
          n_setup[i]++;
        end else begin
          n_gap[i]++;
        end
      end else begin
        check($sformatf("idle_sr[%0d]", i), sr[i], 0);
        check($sformatf("idle_e[%0d]", i), e_out[i], 0);
        if (in_prog[i]) begin
          in_prog[i] = 1'b0;
          if (i == 0) have = (sb0.size() > 0);
          else        have = (sb1.size() > 0);
          check($sformatf("sb_avail[%0d]", i), have, 1);
          if (have) begin
            if (i == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            check($sformatf("sb_sr[%0d]", i), rec_sr[i], e.sr);
            check($sformatf("sb_sr_stable[%0d]", i), sr_chg[i], 0);
            check($sformatf("sb_shape[%0d]", i), shape_bad[i], 0);
            check($sformatf("sb_setup[%0d]", i), n_setup[i], e.setup);
            check($sformatf("sb_pulse[%0d]", i), n_pulse[i], e.pulse);
            check($sformatf("sb_gap[%0d]", i), n_gap[i], e.gap);
            check($sformatf("sb_q[%0d]", i), q_shadow[i], e.q);
          end
        end
      end
      prev_rst[i] = rst[i];
    end
  end

  initial begin
    logic       acc;
    int         idx;
    int         nacc;
    logic [1:0] seq [3];

    for (int i = 0; i < 2; i++) begin
      rst[i]       = 1'b1;
      cmd_valid[i] = 1'b0;
      cmd[i]       = 2'b00;
      err_clr[i]   = 1'b0;
      ready_at[i]  = 0;
      m_err[i]     = 1'b0;
      m_rej[i]     = 0;
      m_q[i]       = 1'b0;
      prev_rst[i]  = 1'b1;
      in_prog[i]   = 1'b0;
    end

    // ---------------- instance 0: HOLD=2, GAP=1 ----------------
    repeat (3) step(0, 1'b0, 2'b00, 1'b0, 1'b1, acc);

    // Single set pulse: sr=10 for 4 cycles, E=0,1,1,0, q_shadow=1.
    step(0, 1'b1, 2'b10, 1'b0, 1'b0, acc);
    idle(0, 6);

    // Three forbidden commands back to back, then clear err.
    repeat (3) step(0, 1'b1, 2'b11, 1'b0, 1'b0, acc);
    step(0, 1'b0, 2'b00, 1'b1, 1'b0, acc);
    idle(0, 2);

    // Back-to-back 10, 00, 01 with cmd_valid held high.
    seq = '{2'b10, 2'b00, 2'b01};
    idx = 0;
    for (int n = 0; n < 40 && idx < 3; n++) begin
      step(0, 1'b1, seq[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check("b2b_accepted", idx, 3);
    idle(0, 6);

    // Reset during the second PULSE cycle of a set.
    step(0, 1'b1, 2'b10, 1'b0, 1'b0, acc);
    idle(0, 2);
    step(0, 1'b0, 2'b00, 1'b0, 1'b1, acc);
    idle(0, 3);

    // Random traffic, with the occasional err_clr and reset.
    repeat (300) begin
      step(0, ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0), acc);
    end
    idle(0, 8);

    // ---------------- instance 1: HOLD=1, GAP=0 ----------------
    repeat (2) step(1, 1'b0, 2'b00, 1'b0, 1'b1, acc);

    // Valid held: a command every 3 cycles, E high 1 cycle each.
    nacc = 0;
    repeat (12) begin
      step(1, 1'b1, 2'($urandom_range(0, 2)), 1'b0, 1'b0, acc);
      if (acc) nacc++;
    end
    check("thru_cnt[1]", nacc, 4);
    idle(1, 4);

    // 256 forbidden commands saturate the reject counter.
    repeat (256) step(1, 1'b1, 2'b11, 1'b0, 1'b0, acc);
    idle(1, 2);
    check("rej_sat[1]", rej_cnt[1], 255);

    repeat (200) begin
      step(1, ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0), acc);
    end
    idle(1, 6);

    check("drain[0]", sb0.size(), 0);
    check("drain[1]", sb1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_drive_seq.md
# sr_drive_seq

Command sequencer sitting directly upstream of the SR latch (`srl`), driving its `sr[1:0]` and `E` inputs. It accepts set/reset/hold commands over a valid/ready handshake and turns each into a timed setup → enable-pulse → gap sequence. It rejects the forbidden S=R=1 combination before it reaches the latch. It also keeps a shadow copy of the expected latch state for checking against `q`.

## Interface
- `HOLD_CYCLES`, default 2: number of cycles `E` is held high per command; legal range ≥1.
- `GAP_CYCLES`, default 1: number of cycles `E` is held low after the pulse before the next command is accepted; legal range ≥0.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd` in 2: command code. 00 = hold, 01 = reset, 10 = set, 11 = forbidden.
- `cmd_ready` out 1: sequencer can accept a command this cycle.
- `err_clr` in 1: clears sticky `err`.
- `sr` out 2: to latch. `sr[1]` = S, `sr[0]` = R.
- `E` out 1: to latch enable.
- `busy` out 1: a command is in progress.
- `err` out 1: sticky; set when a forbidden command is accepted.
- `rej_cnt` out 8: count of rejected forbidden commands; saturates at 255.
- `q_shadow` out 1: expected latch Q after the last executed command.

## Operation
- **States:** IDLE, SETUP, PULSE, GAP.
- **Acceptance:** a command is accepted when `cmd_valid & cmd_ready`. `cmd_ready` = 1 only in IDLE and when `rst` = 0.
- **IDLE:**
  - `sr` = 00, `E` = 0, `busy` = 0.
  - Accepting `cmd` ≠ 11: latch `cmd` into an internal register and go to SETUP.
  - Accepting `cmd` = 11: stay in IDLE, set `err`, increment `rej_cnt` (saturating). `sr` and `E` do not change.
- **SETUP:** 1 cycle. `sr` = latched cmd, `E` = 0, `busy` = 1. Then go to PULSE.
- **PULSE:** `HOLD_CYCLES` cycles. `sr` = latched cmd, `E` = 1, `busy` = 1.
  - On the edge leaving PULSE, `q_shadow` updates: cmd 10 → 1, 01 → 0, 00 → unchanged.
  - Next state: GAP if `GAP_CYCLES` > 0, else IDLE.
- **GAP:** `GAP_CYCLES` cycles. `sr` = latched cmd, `E` = 0, `busy` = 1. Then go to IDLE.
- **err_clr:** clears `err` on the next edge. If `err_clr` coincides with acceptance of a forbidden command, set wins (`err` = 1).
- **Invariant:** `sr` never equals 11, in any state.
- **Counter:** one internal down-counter serves both PULSE and GAP. Its width is sized as clog2(max(HOLD_CYCLES, GAP_CYCLES) + 1).

## Timing
- **Reset values** (edge with `rst` = 1):
  - state = IDLE
  - `sr` = 00, `E` = 0, `busy` = 0, `err` = 0, `rej_cnt` = 0, `q_shadow` = 0
  - `cmd_ready` = 0 while `rst` is high, and 1 on the first cycle after `rst` is low.
- **Command latency:** command accepted at edge N.
  - Cycle N+1: SETUP; `sr` valid, `E` = 0.
  - Cycles N+2 .. N+1+HOLD_CYCLES: `E` = 1.
  - Next GAP_CYCLES cycles: `E` = 0, `sr` held.
  - `cmd_ready` is 1 again at cycle N+2+HOLD_CYCLES+GAP_CYCLES.
- **Throughput:** one command per 1+HOLD_CYCLES+GAP_CYCLES+1 cycles. The IDLE cycle is mandatory between commands, so `E` always has at least one low cycle between pulses, even with `GAP_CYCLES` = 0.
- **Forbidden command:** costs 1 cycle. `cmd_ready` stays 1, so back-to-back forbidden commands count once per cycle.
- **Reset mid-operation:**
  - `E` and `sr` are 0 from the cycle after the reset edge.
  - The in-flight command is dropped and `q_shadow` returns to 0.
- **Inputs outside IDLE:** `cmd` and `cmd_valid` are ignored.
- **Registered outputs:** all outputs are registered, with no combinational input→output path. Exception: `cmd_ready` may be decoded from state and `rst`.

## Test plan
- **Set pulse** (defaults): after reset, `cmd` = 10 valid for one cycle.
  - Expect `sr` = 10 for 4 cycles and `E` = 0,1,1,0 over those cycles.
  - Expect `q_shadow` = 1 after the pulse and `cmd_ready` back to 1 in the 5th cycle after acceptance.
- **Forbidden command:** `cmd` = 11 accepted three cycles in a row.
  - Expect `sr` to stay 00, `E` to stay 0, `err` = 1, `rej_cnt` = 3.
  - Then pulse `err_clr`: `err` = 0 and `rej_cnt` stays 3.
- **Back-to-back commands:** 10, then 00, then 01 with `cmd_valid` held high.
  - Expect `q_shadow` sequence 1, 1, 0.
  - Expect `E` to never be high on consecutive cycles across a command boundary, and `sr` to never be 11.
- **Reset mid-pulse:** assert `rst` during the second PULSE cycle of a set command.
  - Next cycle: `E` = 0, `sr` = 00, `busy` = 0, `q_shadow` = 0.
  - `cmd_ready` = 1 one cycle after `rst` is released.
- **Parameter corners:** `HOLD_CYCLES` = 1, `GAP_CYCLES` = 0.
  - `E` is high for exactly 1 cycle per command; commands are accepted every 3 cycles.
  - Drive 256 forbidden commands: `rej_cnt` saturates at 255.
